lock_sequencer: RTL and testbench
=================================

Name: lock_sequencer

Overview:
- Instruction sequencer that drives the combination-lock CPU datapath control inputs (wrA, selA, selB, aluOp, imm, selR) and reads back its condition codes.
- Fetches 12-bit words from a synchronous program ROM (1-cycle read latency) and decodes each into one control word.
- Latches CC for conditional branches, stalls on an external event, and reports busy/done/err to the top level.

Parameters:
- ADDR_W, 6, program counter / ROM address width (legal range 1..6).
- START_ADDR, 0, PC value loaded on start.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin execution at START_ADDR (honoured only in IDLE or HALT)
- ev  input  1  external event (e.g. key entered), released WAIT
- prog_addr  output  ADDR_W  ROM address (= pc)
- prog_data  input  12  ROM data, valid one cycle after prog_addr
- wrA  output  1  regfile write enable
- selA  output  2  A / destination register select
- selB  output  2  B register select
- aluOp  output  2  ALU operation
- imm  output  1  immediate / memory qualifier
- selR  output  2  immediate selector
- CC  input  6  datapath condition codes (combinational)
- busy  output  1  high in FETCH, LATCH, EXEC, WAIT
- done  output  1  high in HALT
- err  output  1  sticky illegal-instruction flag
- pc  output  ADDR_W  current program counter

Behaviour:
- Reset (async, immediate): state=IDLE, pc=0, ir=0, flags=0, err=0. All control outputs 0, busy=0, done=0. Reset mid-instruction aborts the instruction; no write or store is issued.
- Idle control word: all control outputs 0. This combination can never write the regfile or store.
- States:
  - IDLE: on start, pc<=START_ADDR, go to FETCH.
  - FETCH: prog_addr=pc; go to LATCH.
  - LATCH: ir<=prog_data; go to EXEC.
  - EXEC: drive the decoded control word for exactly one cycle, update pc, then go to FETCH, WAIT or HALT.
  - WAIT: hold the idle control word; when ev=1, pc<=pc+1 and go to FETCH.
  - HALT: done=1; on start, pc<=START_ADDR, err<=0, go to FETCH.
- Normal instructions take 3 cycles; WAIT adds one cycle per cycle ev is low.
- Encoding, ir[11:10]:
  - 00 ALU: aluOp=ir[9:8], selA=ir[7:6], selB=ir[5:4], imm=ir[3], selR=ir[2:1], wrA=ir[0]. In EXEC, flags<=CC and pc<=pc+1.
  - 01 BRANCH: cond = flags[ir[8:6]] for index 0..5, or 1 for index 6/7; taken = cond XOR ir[9]. If taken, pc<=ir[ADDR_W-1:0], else pc<=pc+1. Control word idle; flags unchanged.
  - 10 MEM: selA=ir[7:6], selB=ir[5:4], imm=1, selR=0.
    - ir[9]=0 LOAD: aluOp=10, wrA=1.
    - ir[9]=1 STORE: aluOp=11, wrA=0.
    - pc<=pc+1; flags unchanged.
  - 11 SYS, ir[9:8]:
    - 00 NOP: pc+1.
    - 01 HALT: to HALT, pc holds.
    - 10 WAIT: to WAIT, pc holds until ev.
    - 11 illegal: err<=1, to HALT.
- Unused instruction bits are ignored.
- pc arithmetic: increment is modulo 2^ADDR_W, so the maximum address wraps to 0.
- start outside IDLE/HALT is ignored. ev outside WAIT is ignored. If ev=1 on the EXEC cycle of a WAIT instruction, it is not seen; WAIT samples ev from its first cycle onward.
- Branching on flags uses the CC from the most recent ALU instruction, not live CC.

Test Plan:
- Reset: assert rst_n=0 mid-EXEC of a STORE -> all control outputs, busy, done, err and pc are 0 in the same cycle, and no store occurs.
- ALU: ROM[0]=12'h0D5 (aluOp=00, selA=3, selB=1, imm=0, wrA=1), start -> EXEC on the 3rd cycle after start shows wrA=1, selA=3, selB=1, aluOp=00 for exactly one cycle; pc=1.
- Branch: ALU op whose CC[0]=1, then ROM[1]=12'h405 (branch on flags[0]) -> pc=5. Repeat with CC[0]=0 -> pc=2. ir[9]=1 inverts both outcomes.
- Memory: LOAD 12'h850 -> aluOp=10, imm=1, wrA=1, selA=1, selB=1. STORE 12'hA50 -> aluOp=11, imm=1, wrA=0.
- WAIT/HALT: 12'hE00 with ev low for 10 cycles -> busy=1, pc steady, idle control word. ev pulse -> pc+1. 12'hD00 -> done=1, busy=0; start re-runs from START_ADDR.
- Wrap/illegal: NOP at address 63 (ADDR_W=6) -> pc=0. 12'hF00 -> err=1 and done=1; err clears on the next start.

Source files
------------

// File: rtl/lock_sequencer.sv
// lock_sequencer: fetch/latch/execute sequencer that turns 12-bit ROM words into
// one-cycle control words for the combination-lock datapath.
module lock_sequencer #(
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned START_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              ev,
  output logic [ADDR_W-1:0] prog_addr,
  input  logic [11:0]       prog_data,
  output logic              wrA,
  output logic [1:0]        selA,
  output logic [1:0]        selB,
  output logic [1:0]        aluOp,
  output logic              imm,
  output logic [1:0]        selR,
  input  logic [5:0]        CC,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] pc
);

  localparam int unsigned IR_W = 12;
  localparam int unsigned CC_W = 6;

  localparam logic [1:0] OP_ALU = 2'b00;
  localparam logic [1:0] OP_BR  = 2'b01;
  localparam logic [1:0] OP_MEM = 2'b10;

  localparam logic [1:0] SYS_NOP  = 2'b00;
  localparam logic [1:0] SYS_HALT = 2'b01;
  localparam logic [1:0] SYS_WAIT = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_EXEC,
    S_WAIT,
    S_HALT
  } state_e;

  typedef struct packed {
    logic       wr_a;
    logic [1:0] sel_a;
    logic [1:0] sel_b;
    logic [1:0] alu_op;
    logic       imm;
    logic [1:0] sel_r;
  } ctrl_t;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_inc_c;
  logic [IR_W-1:0]   ir_q, ir_d;
  logic [CC_W-1:0]   flags_q, flags_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  ctrl_t             ctrl_q, ctrl_d;
  ctrl_t             dec_c;
  logic [7:0]        cond_vec_c;
  logic              taken_c;

  assign pc_inc_c   = pc_q + ADDR_W'(1);
  // Condition indices 6 and 7 are unconditional; bit 9 inverts the sense.
  assign cond_vec_c = {2'b11, flags_q};
  assign taken_c    = cond_vec_c[ir_q[8:6]] ^ ir_q[9];

  // Decode the word arriving from ROM so the control word is registered into EXEC.
  always_comb begin
    dec_c = '0;
    case (prog_data[11:10])
      OP_ALU: begin
        dec_c.alu_op = prog_data[9:8];
        dec_c.sel_a  = prog_data[7:6];
        dec_c.sel_b  = prog_data[5:4];
        dec_c.imm    = prog_data[3];
        dec_c.sel_r  = prog_data[2:1];
        dec_c.wr_a   = prog_data[0];
      end
      OP_MEM: begin
        dec_c.sel_a  = prog_data[7:6];
        dec_c.sel_b  = prog_data[5:4];
        dec_c.imm    = 1'b1;
        dec_c.alu_op = prog_data[9] ? 2'b11 : 2'b10;
        dec_c.wr_a   = ~prog_data[9];
      end
      default: dec_c = '0;
    endcase
  end

  // Next-state, pc and flag update.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    flags_d = flags_q;
    err_d   = err_q;
    ctrl_d  = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d    = ADDR_W'(START_ADDR);
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        ir_d    = prog_data;
        ctrl_d  = dec_c;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (ir_q[11:10])
          OP_ALU: begin
            flags_d = CC;
            pc_d    = pc_inc_c;
          end
          OP_BR:  pc_d = taken_c ? ir_q[ADDR_W-1:0] : pc_inc_c;
          OP_MEM: pc_d = pc_inc_c;
          default: begin
            case (ir_q[9:8])
              SYS_NOP:  pc_d = pc_inc_c;
              SYS_HALT: state_d = S_HALT;
              SYS_WAIT: state_d = S_WAIT;
              default: begin
                err_d   = 1'b1;
                state_d = S_HALT;
              end
            endcase
          end
        endcase
      end
      S_WAIT: begin
        if (ev) begin
          pc_d    = pc_inc_c;
          state_d = S_FETCH;
        end
      end
      S_HALT: begin
        if (start) begin
          pc_d    = ADDR_W'(START_ADDR);
          err_d   = 1'b0;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_FETCH) || (state_d == S_LATCH) ||
             (state_d == S_EXEC)  || (state_d == S_WAIT);
    done_d = (state_d == S_HALT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      flags_q <= flags_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign prog_addr = pc_q;
  assign pc        = pc_q;
  assign wrA       = ctrl_q.wr_a;
  assign selA      = ctrl_q.sel_a;
  assign selB      = ctrl_q.sel_b;
  assign aluOp     = ctrl_q.alu_op;
  assign imm       = ctrl_q.imm;
  assign selR      = ctrl_q.sel_r;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_lock_sequencer.sv
// tb_lock_sequencer: directed ROM programs; expected control words and status are
// queued with cycle stamps and checked by an independent negedge monitor.
`timescale 1ns/1ps
module tb_lock_sequencer;

  localparam int unsigned ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              ev;
  logic [ADDR_W-1:0] prog_addr;
  logic [11:0]       prog_data;
  logic              wrA;
  logic [1:0]        selA;
  logic [1:0]        selB;
  logic [1:0]        aluOp;
  logic              imm;
  logic [1:0]        selR;
  logic [5:0]        CC;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] pc;

  logic [11:0] rom [64];

  typedef struct {
    int          cyc;
    logic [9:0]  ctrl;
    string       name;
  } ctrl_exp_t;

  typedef struct {
    int                cyc;
    logic [ADDR_W-1:0] pc;
    logic              busy;
    logic              done;
    logic              err;
    string             name;
  } stat_exp_t;

  ctrl_exp_t cq[$];
  stat_exp_t sq[$];
  int cyc      = 0;
  int checks   = 0;
  int failures = 0;

  lock_sequencer #(.ADDR_W(ADDR_W), .START_ADDR(0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .ev        (ev),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .wrA       (wrA),
    .selA      (selA),
    .selB      (selB),
    .aluOp     (aluOp),
    .imm       (imm),
    .selR      (selR),
    .CC        (CC),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .pc        (pc)
  );

  always #5 clk = ~clk;

  // Synchronous program ROM, one cycle read latency.
  always @(posedge clk) prog_data <= rom[prog_addr];

  // Monitor: any non-idle control word pops the control queue; status entries are due by cycle.
  always @(negedge clk) begin
    logic [9:0] act;
    ctrl_exp_t  e;
    stat_exp_t  s;
    cyc = cyc + 1;
    act = {wrA, selA, selB, aluOp, imm, selR};
    if (act != 10'd0) begin
      checks = checks + 1;
      if (cq.size() == 0) begin
        failures = failures + 1;
        $display("FAIL ctrl_unexpected cyc=%0d actual=%h required=idle", cyc, act);
      end else begin
        e = cq.pop_front();
        if (e.cyc != cyc || e.ctrl != act) begin
          failures = failures + 1;
          $display("FAIL %s actual=%h@cyc%0d required=%h@cyc%0d", e.name, act, cyc, e.ctrl, e.cyc);
        end
      end
    end
    while (cq.size() != 0 && cq[0].cyc < cyc) begin
      e = cq.pop_front();
      checks = checks + 1;
      failures = failures + 1;
      $display("FAIL %s actual=idle required=%h@cyc%0d", e.name, e.ctrl, e.cyc);
    end
    while (sq.size() != 0 && sq[0].cyc <= cyc) begin
      s = sq.pop_front();
      checks = checks + 1;
      if (s.cyc != cyc || pc !== s.pc || busy !== s.busy || done !== s.done || err !== s.err) begin
        failures = failures + 1;
        $display("FAIL %s cyc=%0d actual pc=%0d busy=%b done=%b err=%b required pc=%0d busy=%b done=%b err=%b",
                 s.name, cyc, pc, busy, done, err, s.pc, s.busy, s.done, s.err);
      end
    end
  end

  function automatic logic [9:0] mk(input logic w, input logic [1:0] a, input logic [1:0] b,
                                    input logic [1:0] op, input logic i, input logic [1:0] r);
    return {w, a, b, op, i, r};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Advance to just after the rising edge that opens cycle c.
  task automatic goto(input int c);
    while (cyc + 1 < c) tick(1);
  endtask

  task automatic exp_ctrl(input int c, input string nm, input logic [9:0] v);
    ctrl_exp_t e;
    e.cyc = c; e.ctrl = v; e.name = nm;
    cq.push_back(e);
  endtask

  task automatic exp_stat(input int c, input string nm, input logic [ADDR_W-1:0] p,
                          input logic b, input logic d, input logic r);
    stat_exp_t s;
    s.cyc = c; s.pc = p; s.busy = b; s.done = d; s.err = r; s.name = nm;
    sq.push_back(s);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b;
    for (int i = 0; i < 64; i++) rom[i] = 12'hD00;
    rst_n = 1'b0;
    start = 1'b0;
    ev    = 1'b0;
    CC    = 6'd0;
    exp_stat(2, "reset_state", 6'd0, 1'b0, 1'b0, 1'b0);
    tick(3);
    rst_n = 1'b1;
    tick(1);

    // ALU then branch on flags[0], CC[0]=1 at the ALU, live CC dropped afterwards
    rom[0] = 12'h0D5; rom[1] = 12'h405; rom[2] = 12'hD00; rom[5] = 12'hD00;
    CC = 6'b000001;
    b = cyc + 1; start = 1'b1;
    exp_stat(b + 1, "start_fetch", 6'd0, 1'b1, 1'b0, 1'b0);
    exp_stat(b + 3, "alu_exec_pc", 6'd0, 1'b1, 1'b0, 1'b0);
    exp_ctrl(b + 3, "alu_ctrl", mk(1'b1, 2'd3, 2'd1, 2'd0, 1'b0, 2'd2));
    exp_stat(b + 4, "alu_pc_inc", 6'd1, 1'b1, 1'b0, 1'b0);
    exp_stat(b + 7, "br_taken", 6'd5, 1'b1, 1'b0, 1'b0);
    exp_stat(b + 9, "halt_exec", 6'd5, 1'b1, 1'b0, 1'b0);
    exp_stat(b + 10, "halt_a", 6'd5, 1'b0, 1'b1, 1'b0);
    tick(1); start = 1'b0;
    goto(b + 4); CC = 6'd0;
    goto(b + 11);

    // Same program with CC[0]=0: branch falls through
    b = cyc + 1; start = 1'b1;
    exp_ctrl(b + 3, "alu_ctrl_b", mk(1'b1, 2'd3, 2'd1, 2'd0, 1'b0, 2'd2));
    exp_stat(b + 4, "alu_pc_b", 6'd1, 1'b1, 1'b0, 1'b0);
    exp_stat(b + 7, "br_not_taken", 6'd2, 1'b1, 1'b0, 1'b0);
    exp_stat(b + 10, "halt_b", 6'd2, 1'b0, 1'b1, 1'b0);
    tick(1); start = 1'b0;
    goto(b + 11);

    // Inverted branch, flags[0]=1: not taken even though live CC is 0 at the branch
    rom[1] = 12'h605;
    CC = 6'b000001;
    b = cyc + 1; start = 1'b1;
    exp_ctrl(b + 3, "alu_ctrl_c", mk(1'b1, 2'd3, 2'd1, 2'd0, 1'b0, 2'd2));
    exp_stat(b + 7, "brinv_not_taken", 6'd2, 1'b1, 1'b0, 1'b0);
    exp_stat(b + 10, "halt_c", 6'd2, 1'b0, 1'b1, 1'b0);
    tick(1); start = 1'b0;
    goto(b + 4); CC = 6'd0;
    goto(b + 11);

    // Inverted branch, flags[0]=0: taken
    b = cyc + 1; start = 1'b1;
    exp_ctrl(b + 3, "alu_ctrl_d", mk(1'b1, 2'd3, 2'd1, 2'd0, 1'b0, 2'd2));
    exp_stat(b + 7, "brinv_taken", 6'd5, 1'b1, 1'b0, 1'b0);
    exp_stat(b + 10, "halt_d", 6'd5, 1'b0, 1'b1, 1'b0);
    tick(1); start = 1'b0;
    goto(b + 11);

    // LOAD and STORE control words
    rom[0] = 12'h850; rom[1] = 12'hA50; rom[2] = 12'hD00;
    b = cyc + 1; start = 1'b1;
    exp_ctrl(b + 3, "load_ctrl", mk(1'b1, 2'd1, 2'd1, 2'd2, 1'b1, 2'd0));
    exp_ctrl(b + 6, "store_ctrl", mk(1'b0, 2'd1, 2'd1, 2'd3, 1'b1, 2'd0));
    exp_stat(b + 7, "mem_pc", 6'd2, 1'b1, 1'b0, 1'b0);
    exp_stat(b + 10, "halt_mem", 6'd2, 1'b0, 1'b1, 1'b0);
    tick(1); start = 1'b0;
    goto(b + 11);

    // WAIT: ev high up to and including EXEC is ignored; start during WAIT is ignored
    rom[0] = 12'hE00; rom[1] = 12'hD00;
    b = cyc + 1; start = 1'b1; ev = 1'b1;
    exp_stat(b + 3, "wait_exec", 6'd0, 1'b1, 1'b0, 1'b0);
    for (int k = 4; k <= 14; k++) exp_stat(b + k, "wait_hold", 6'd0, 1'b1, 1'b0, 1'b0);
    exp_stat(b + 15, "wait_release", 6'd1, 1'b1, 1'b0, 1'b0);
    exp_stat(b + 18, "halt_wait", 6'd1, 1'b0, 1'b1, 1'b0);
    tick(1); start = 1'b0;
    goto(b + 4); ev = 1'b0;
    goto(b + 12); start = 1'b1;
    goto(b + 13); start = 1'b0;
    goto(b + 14); ev = 1'b1;
    goto(b + 15); ev = 1'b0;
    goto(b + 19);

    // pc wraps from 63 to 0
    rom[0] = 12'h5BF; rom[63] = 12'hC00;
    b = cyc + 1; start = 1'b1;
    exp_stat(b + 4, "br_to_63", 6'd63, 1'b1, 1'b0, 1'b0);
    exp_stat(b + 7, "pc_wrap", 6'd0, 1'b1, 1'b0, 1'b0);
    exp_stat(b + 10, "halt_wrap", 6'd0, 1'b0, 1'b1, 1'b0);
    tick(1); start = 1'b0;
    goto(b + 4); rom[0] = 12'hD00;
    goto(b + 11);

    // Illegal SYS sets sticky err and halts
    rom[0] = 12'hF00;
    b = cyc + 1; start = 1'b1;
    exp_stat(b + 3, "illegal_exec", 6'd0, 1'b1, 1'b0, 1'b0);
    exp_stat(b + 4, "illegal_err", 6'd0, 1'b0, 1'b1, 1'b1);
    exp_stat(b + 6, "err_sticky", 6'd0, 1'b0, 1'b1, 1'b1);
    tick(1); start = 1'b0;
    goto(b + 7);

    // Restart clears err; reset during STORE EXEC clears everything with no store seen
    rom[0] = 12'hC00; rom[1] = 12'hA50; rom[2] = 12'hD00;
    b = cyc + 1; start = 1'b1;
    exp_stat(b + 1, "err_clear", 6'd0, 1'b1, 1'b0, 1'b0);
    exp_stat(b + 4, "nop_pc", 6'd1, 1'b1, 1'b0, 1'b0);
    exp_stat(b + 6, "reset_abort", 6'd0, 1'b0, 1'b0, 1'b0);
    exp_stat(b + 8, "reset_hold", 6'd0, 1'b0, 1'b0, 1'b0);
    exp_stat(b + 11, "idle_after_reset", 6'd0, 1'b0, 1'b0, 1'b0);
    tick(1); start = 1'b0;
    goto(b + 6); rst_n = 1'b0;
    goto(b + 9); rst_n = 1'b1;
    goto(b + 13);

    while (cq.size() != 0) begin
      ctrl_exp_t e;
      e = cq.pop_front();
      checks = checks + 1;
      failures = failures + 1;
      $display("FAIL %s actual=never required=%h@cyc%0d", e.name, e.ctrl, e.cyc);
    end
    while (sq.size() != 0) begin
      stat_exp_t s;
      s = sq.pop_front();
      checks = checks + 1;
      failures = failures + 1;
      $display("FAIL %s actual=never required pc=%0d@cyc%0d", s.name, s.pc, s.cyc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
